// File: rtl/wavetable_pkg.sv
// Shared constants and state encoding for the wavetable loader.
package wavetable_pkg;

    localparam int unsigned WT_LENGTH    = 4096;
    localparam int unsigned WT_BITDEPTH  = 16;
    localparam int unsigned WT_NUM_BANKS = 4;
    localparam int unsigned WT_ADDR_W    = 12;
    localparam int unsigned WT_BANK_W    = 2;

    typedef enum logic [2:0] {
        StIdle,
        StBank,
        StLo,
        StHi,
        StWrite,
        StCsum,
        StFinish
    } wt_state_e;

endpackage

// File: rtl/wavetable_loader.sv
// Byte-stream to wavetable RAM writer: bank byte, then LENGTH little-endian 16-bit samples.
// Optional trailing checksum byte when WAVETABLE_LOADER_CHECKSUM_EN is defined.
module wavetable_loader
    import wavetable_pkg::*;
#(
    parameter int unsigned LENGTH    = WT_LENGTH,
    parameter int unsigned BITDEPTH  = WT_BITDEPTH,
    parameter int unsigned NUM_BANKS = WT_NUM_BANKS
) (
    input  logic                                         Clk,
    input  logic                                         Reset_n,
    input  logic                                         Load_Start,
    input  logic [7:0]                                   In_Data,
    input  logic                                         In_Valid,
    output logic                                         In_Ready,
    output logic                                         Wr_En,
    output logic [$clog2(NUM_BANKS)+$clog2(LENGTH)-1:0]  Wr_Addr,
    output logic [BITDEPTH-1:0]                          Wr_Data,
    output logic                                         Busy,
    output logic                                         Done,
    output logic                                         Error
);

    localparam int unsigned IDX_W  = $clog2(LENGTH);
    localparam int unsigned BANK_W = $clog2(NUM_BANKS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LENGTH - 1);

    wt_state_e                   state_q, state_d;
    logic [IDX_W-1:0]            index_q, index_d;
    logic [BANK_W-1:0]           bank_q, bank_d;
    logic [7:0]                  low_q, low_d;
    logic [BANK_W+IDX_W-1:0]     addr_q, addr_d;
    logic [BITDEPTH-1:0]         data_q, data_d;
    logic                        xfer;

    assign In_Ready = (state_q == StBank) || (state_q == StLo) || (state_q == StHi)
                      || (state_q == StCsum);
    assign xfer     = In_Valid && In_Ready;
    assign Wr_En    = (state_q == StWrite);
    assign Busy     = (state_q != StIdle);
    assign Done     = (state_q == StFinish);
    assign Wr_Addr  = addr_q;
    assign Wr_Data  = data_q;

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        bank_d  = bank_q;
        low_d   = low_q;
        addr_d  = addr_q;
        data_d  = data_q;
        unique case (state_q)
            StIdle: begin
                if (Load_Start) begin
                    state_d = StBank;
                    index_d = '0;
                end
            end
            StBank: begin
                if (xfer) begin
                    bank_d  = In_Data[BANK_W-1:0];
                    state_d = StLo;
                end
            end
            StLo: begin
                if (xfer) begin
                    low_d   = In_Data;
                    state_d = StHi;
                end
            end
            StHi: begin
                if (xfer) begin
                    data_d  = BITDEPTH'({In_Data, low_q});
                    addr_d  = {bank_q, index_q};
                    state_d = StWrite;
                end
            end
            StWrite: begin
                if (index_q == LAST_IDX) begin
`ifdef WAVETABLE_LOADER_CHECKSUM_EN
                    state_d = StCsum;
`else
                    state_d = StFinish;
`endif
                end else begin
                    index_d = index_q + 1'b1;
                    state_d = StLo;
                end
            end
`ifdef WAVETABLE_LOADER_CHECKSUM_EN
            StCsum: begin
                if (xfer) begin
                    state_d = StFinish;
                end
            end
`endif
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= StIdle;
            index_q <= '0;
            bank_q  <= '0;
            low_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            bank_q  <= bank_d;
            low_q   <= low_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

`ifdef WAVETABLE_LOADER_CHECKSUM_EN
    logic [7:0] sum_q, sum_d;
    logic       error_q, error_d;

    // Sum covers the bank byte and every sample byte, not the checksum byte itself.
    always_comb begin
        sum_d   = sum_q;
        error_d = error_q;
        if ((state_q == StIdle) && Load_Start) begin
            sum_d   = '0;
            error_d = 1'b0;
        end else if (xfer && (state_q != StCsum)) begin
            sum_d = sum_q + In_Data;
        end else if (xfer && (In_Data != sum_q)) begin
            error_d = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sum_q   <= '0;
            error_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            error_q <= error_d;
        end
    end

    assign Error = error_q;
`else
    assign Error = 1'b0;
`endif

endmodule

// File: tb/tb_wavetable_loader.sv
// Scoreboard bench for wavetable_loader; checksum tests follow WAVETABLE_LOADER_CHECKSUM_EN.
module tb_wavetable_loader;

    logic        Clk;
    logic        Reset_n;
    logic        Load_Start;
    logic [7:0]  In_Data;
    logic        In_Valid;
    logic        In_Ready;
    logic        Wr_En;
    logic [13:0] Wr_Addr;
    logic [15:0] Wr_Data;
    logic        Busy;
    logic        Done;
    logic        Error;

    wavetable_loader dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .Load_Start (Load_Start),
        .In_Data    (In_Data),
        .In_Valid   (In_Valid),
        .In_Ready   (In_Ready),
        .Wr_En      (Wr_En),
        .Wr_Addr    (Wr_Addr),
        .Wr_Data    (Wr_Data),
        .Busy       (Busy),
        .Done       (Done),
        .Error      (Error)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          wr_count = 0;
    int          done_count = 0;
    logic [29:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            if (n_err <= 40) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write monitor: every strobe must match the next scoreboard entry.
    always @(negedge Clk) begin
        if (Done) done_count++;
        if (Wr_En) begin
            logic [29:0] e;
            wr_count++;
            check_eq("rdy_in_write", {31'd0, In_Ready}, 32'd0);
            if (exp_q.size() == 0) begin
                check_eq("wr_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("wr_addr", {18'd0, Wr_Addr}, {18'd0, e[29:16]});
                check_eq("wr_data", {16'd0, Wr_Data}, {16'd0, e[15:0]});
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit got;
        if (gaps) begin
            while ($urandom_range(1, 0) == 0) begin
                In_Valid = 1'b0;
                @(posedge Clk); #1;
            end
        end
        In_Data  = b;
        In_Valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 1000 && !got; i++) begin
            @(negedge Clk);
            got = In_Ready;
        end
        if (!got) check_eq("send_timeout", 32'd0, 32'd1);
        else begin
            @(posedge Clk); #1;
        end
    endtask

    task automatic pulse_start();
        Load_Start = 1'b1;
        @(posedge Clk); #1;
        Load_Start = 1'b0;
    endtask

    // Drives a load of n samples k = 0..n-1; Load_Start is re-asserted at sample ls_at.
    task automatic run_load(input logic [7:0] bank_byte, input bit gaps, input int n,
                            input int ls_at, output logic [7:0] sum);
        logic [15:0] k;
        pulse_start();
        check_eq("busy_start", {31'd0, Busy}, 32'd1);
        sum = bank_byte;
        send_byte(bank_byte, gaps);
        for (int i = 0; i < n; i++) begin
            k = 16'(i);
            if (i == ls_at) Load_Start = 1'b1;
            send_byte(k[7:0], gaps);
            exp_q.push_back({bank_byte[1:0], k[11:0], k});
            send_byte(k[15:8], gaps);
            Load_Start = 1'b0;
            sum = sum + k[7:0] + k[15:8];
        end
    endtask

    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge Clk);
            seen = Done;
        end
    endtask

    task automatic finish_load(input logic [7:0] csum, input logic exp_error);
        bit seen;
`ifdef WAVETABLE_LOADER_CHECKSUM_EN
        send_byte(csum, 1'b0);
`else
        if (csum == 8'hxx) $display("unreachable");
`endif
        In_Valid = 1'b0;
        wait_done(seen);
        check_eq("done_seen", {31'd0, seen}, 32'd1);
        check_eq("error_at_done", {31'd0, Error}, {31'd0, exp_error});
        @(negedge Clk);
        check_eq("busy_fall", {31'd0, Busy}, 32'd0);
        check_eq("done_one_cycle", {31'd0, Done}, 32'd0);
        check_eq("done_count", done_count, 32'd1);
        check_eq("write_count", wr_count, 32'd4096);
        check_eq("queue_empty", exp_q.size(), 32'd0);
    endtask

    initial begin
        logic [7:0] sum;
        Reset_n    = 1'b1;
        Load_Start = 1'b0;
        In_Data    = 8'h00;
        In_Valid   = 1'b0;
        #3 Reset_n = 1'b0;
        #1;
        check_eq("rst_ready", {31'd0, In_Ready}, 32'd0);
        check_eq("rst_wren", {31'd0, Wr_En}, 32'd0);
        check_eq("rst_busy", {31'd0, Busy}, 32'd0);
        check_eq("rst_done", {31'd0, Done}, 32'd0);
        check_eq("rst_error", {31'd0, Error}, 32'd0);
        check_eq("rst_addr", {18'd0, Wr_Addr}, 32'd0);
        check_eq("rst_data", {16'd0, Wr_Data}, 32'd0);
        repeat (2) @(posedge Clk);
        #1 Reset_n = 1'b1;
        @(posedge Clk); #1;

        // Bytes offered while idle are refused; 0x57 would select bank 3 if it leaked in.
        In_Data  = 8'h57;
        In_Valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            check_eq("idle_ready", {31'd0, In_Ready}, 32'd0);
        end
        @(posedge Clk); #1;

        // Full load to bank 2, valid held, stray Load_Start mid-load.
        wr_count = 0; done_count = 0;
        run_load(8'h02, 1'b0, 4096, 50, sum);
        finish_load(sum, 1'b0);

        // Bank byte 0xFD lands in bank 1, with random valid gaps.
        @(posedge Clk); #1;
        wr_count = 0; done_count = 0;
        run_load(8'hFD, 1'b1, 4096, -1, sum);
        finish_load(sum, 1'b0);

        // Reset after sample 100: outputs clear at once, no more writes, no Done.
        @(posedge Clk); #1;
        wr_count = 0; done_count = 0;
        run_load(8'h03, 1'b0, 101, -1, sum);
        @(posedge Clk); #1;
        Reset_n = 1'b0;
        #1;
        check_eq("midrst_busy", {31'd0, Busy}, 32'd0);
        check_eq("midrst_ready", {31'd0, In_Ready}, 32'd0);
        check_eq("midrst_addr", {18'd0, Wr_Addr}, 32'd0);
        check_eq("midrst_data", {16'd0, Wr_Data}, 32'd0);
        repeat (3) @(posedge Clk);
        #1 Reset_n = 1'b1;
        repeat (10) @(posedge Clk);
        #1;
        check_eq("midrst_writes", wr_count, 32'd101);
        check_eq("midrst_no_done", done_count, 32'd0);
        check_eq("midrst_queue", exp_q.size(), 32'd0);

        // Restart from index 0 in bank 0, then abort again.
        run_load(8'h00, 1'b0, 5, -1, sum);
        In_Valid = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        check_eq("restart_writes", wr_count, 32'd106);
        check_eq("restart_queue", exp_q.size(), 32'd0);
        Reset_n = 1'b0;
        @(posedge Clk); #1;
        Reset_n = 1'b1;
        @(posedge Clk); #1;

`ifdef WAVETABLE_LOADER_CHECKSUM_EN
        // Wrong checksum: Error sticks past Done, clears on the next Load_Start.
        wr_count = 0; done_count = 0;
        run_load(8'h01, 1'b0, 4096, -1, sum);
        finish_load(sum ^ 8'h01, 1'b1);
        repeat (3) @(negedge Clk);
        check_eq("error_sticky", {31'd0, Error}, 32'd1);
        @(posedge Clk); #1;
        pulse_start();
        check_eq("error_cleared", {31'd0, Error}, 32'd0);
        Reset_n = 1'b0;
        @(posedge Clk); #1;
        Reset_n = 1'b1;
        @(posedge Clk); #1;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
